// File: rtl/spi_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : spi_bus_arbiter
// Description : Round-robin arbiter that hands the single SPI byte engine to
//               one of two byte-stream requesters for a whole burst. It owns
//               chip select and sequences CS setup, byte issue and completion
//               wait. A burst ends on a last-marked byte or an idle timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_bus_arbiter #(
  parameter int CS_SETUP       = 2,    // cycles from cs_n fall to first start, 1..15
  parameter int TIMEOUT_CYCLES = 200   // idle ISSUE cycles before abort, 0 = never
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  tx_valid_i,
  input  logic [15:0] tx_data_i,
  input  logic [1:0]  tx_last_i,
  output logic [1:0]  tx_ready_o,
  output logic [1:0]  rx_valid_o,
  output logic [7:0]  rx_data_o,
  output logic [1:0]  grant_o,
  output logic        cs_n_o,
  output logic        eng_start_o,
  output logic [7:0]  eng_data_o,
  input  logic        eng_busy_i,
  input  logic        eng_done_i,
  input  logic [7:0]  eng_rx_i,
  output logic        timeout_o
);

  localparam logic [3:0] SETUP_LAST    = 4'(CS_SETUP - 1);
  localparam logic [8:0] TIMEOUT_LIMIT = 9'(TIMEOUT_CYCLES);
  localparam bit         TIMEOUT_EN    = (TIMEOUT_CYCLES != 0);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETUP   = 3'd1,
    ISSUE   = 3'd2,
    WAIT    = 3'd3,
    RELEASE = 3'd4
  } state_t;

  state_t     state;
  logic [3:0] setup_cnt;
  logic [7:0] timer;
  logic       last_owner;   // index of the requester granted most recently
  logic       last_flag;    // last marker of the byte currently in flight

  logic       owner;        // index of the granted requester
  logic       owner_valid;
  logic       owner_last;
  logic [7:0] owner_data;
  logic       in_issue;
  logic       handshake;
  logic       req_any;
  logic       winner;
  logic [8:0] timer_next;
  logic       timeout_hit;

  // Select the granted requester's byte stream and form the issue handshake
  always_comb begin
    owner       = grant_o[1];
    owner_valid = owner ? tx_valid_i[1] : tx_valid_i[0];
    owner_last  = owner ? tx_last_i[1]  : tx_last_i[0];
    owner_data  = owner ? tx_data_i[15:8] : tx_data_i[7:0];
    in_issue    = (state == ISSUE);
    handshake   = in_issue & owner_valid & ~eng_busy_i;
    eng_start_o = handshake;
    tx_ready_o  = {handshake & owner, handshake & ~owner};
    eng_data_o  = in_issue ? owner_data : 8'h00;
  end

  // Round-robin pick: on contention the requester that did not own last wins
  always_comb begin
    req_any = |tx_valid_i;
    case (tx_valid_i)
      2'b01:   winner = 1'b0;
      2'b10:   winner = 1'b1;
      2'b11:   winner = ~last_owner;
      default: winner = 1'b0;
    endcase
  end

  // Idle timer advance and expiry detect; the timer saturates when disabled
  always_comb begin
    timer_next  = {1'b0, timer} + 9'd1;
    timeout_hit = TIMEOUT_EN && (timer_next == TIMEOUT_LIMIT);
  end

  // Burst sequencer with registered chip select, grant and response outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      cs_n_o     <= 1'b1;
      grant_o    <= 2'b00;
      rx_valid_o <= 2'b00;
      rx_data_o  <= 8'h00;
      timeout_o  <= 1'b0;
      last_owner <= 1'b1;
      timer      <= 8'h00;
      setup_cnt  <= 4'h0;
      last_flag  <= 1'b0;
    end else begin
      rx_valid_o <= 2'b00;
      timeout_o  <= 1'b0;
      case (state)
        IDLE: begin
          if (req_any) begin
            grant_o    <= winner ? 2'b10 : 2'b01;
            last_owner <= winner;
            cs_n_o     <= 1'b0;
            setup_cnt  <= 4'h0;
            timer      <= 8'h00;
            state      <= SETUP;
          end
        end
        SETUP: begin
          if (setup_cnt == SETUP_LAST) begin
            state <= ISSUE;
          end else begin
            setup_cnt <= setup_cnt + 4'h1;
          end
        end
        ISSUE: begin
          if (handshake) begin
            last_flag <= owner_last;
            timer     <= 8'h00;
            state     <= WAIT;
          end else if (timeout_hit) begin
            timeout_o <= 1'b1;
            cs_n_o    <= 1'b1;
            grant_o   <= 2'b00;
            timer     <= 8'h00;
            state     <= RELEASE;
          end else if (timer != 8'hFF) begin
            timer <= timer_next[7:0];
          end
        end
        WAIT: begin
          if (eng_done_i) begin
            rx_data_o  <= eng_rx_i;
            rx_valid_o <= owner ? 2'b10 : 2'b01;
            if (last_flag) begin
              cs_n_o  <= 1'b1;
              grant_o <= 2'b00;
              state   <= RELEASE;
            end else begin
              state <= ISSUE;
            end
          end
        end
        RELEASE: begin
          state <= IDLE;
        end
        default: begin
          cs_n_o  <= 1'b1;
          grant_o <= 2'b00;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_spi_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_bus_arbiter
// Description : Directed bench for spi_bus_arbiter with a behavioural byte
//               engine (fixed 8-cycle transfer, bench-chosen MISO byte).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_bus_arbiter;

  localparam int CS_SETUP = 2;
  localparam int TMO      = 5;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  tx_valid;
  logic [15:0] tx_data;
  logic [1:0]  tx_last;
  logic [1:0]  tx_ready_o;
  logic [1:0]  rx_valid_o;
  logic [7:0]  rx_data_o;
  logic [1:0]  grant_o;
  logic        cs_n_o;
  logic        eng_start_o;
  logic [7:0]  eng_data_o;
  logic        eng_busy;
  logic        eng_done;
  logic [7:0]  eng_rx;
  logic        timeout_o;

  logic [3:0]  eng_cnt;
  logic [7:0]  eng_resp;
  int          cyc = 0;
  int          vectors = 0;
  int          errors = 0;

  spi_bus_arbiter #(.CS_SETUP(CS_SETUP), .TIMEOUT_CYCLES(TMO)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .tx_valid_i  (tx_valid),
    .tx_data_i   (tx_data),
    .tx_last_i   (tx_last),
    .tx_ready_o  (tx_ready_o),
    .rx_valid_o  (rx_valid_o),
    .rx_data_o   (rx_data_o),
    .grant_o     (grant_o),
    .cs_n_o      (cs_n_o),
    .eng_start_o (eng_start_o),
    .eng_data_o  (eng_data_o),
    .eng_busy_i  (eng_busy),
    .eng_done_i  (eng_done),
    .eng_rx_i    (eng_rx),
    .timeout_o   (timeout_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural engine: start sampled at edge S, done pulse visible after S+8
  always @(posedge clk) begin
    if (!rst_n) begin
      eng_busy <= 1'b0;
      eng_done <= 1'b0;
      eng_rx   <= 8'h00;
      eng_cnt  <= 4'h0;
    end else begin
      eng_done <= 1'b0;
      if (eng_busy) begin
        if (eng_cnt == 4'h0) begin
          eng_busy <= 1'b0;
          eng_done <= 1'b1;
          eng_rx   <= eng_resp;
        end else begin
          eng_cnt <= eng_cnt - 4'h1;
        end
      end else if (eng_start_o) begin
        eng_busy <= 1'b1;
        eng_cnt  <= 4'd7;
      end
    end
  end

  typedef struct packed {
    logic       r;
    logic [7:0] data;
    logic       last;
    logic [7:0] resp;
    logic       first;
    logic [1:0] exp_grant;
    logic [1:0] exp_rxv;
  } vec_t;

  localparam int NV = 7;
  vec_t tbl [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wait_start(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 64; n++) begin
      #1;
      if (eng_start_o) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic wait_rx(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 64; n++) begin
      @(negedge clk);
      #1;
      if (rx_valid_o != 2'b00) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin : main
    vec_t v;
    bit   ok;
    int   c_cs;
    int   c_st;
    int   c_rx;

    tbl[0] = '{1'b0, 8'hA5, 1'b1, 8'h3C, 1'b1, 2'b01, 2'b01};
    tbl[1] = '{1'b1, 8'h11, 1'b0, 8'hEE, 1'b1, 2'b10, 2'b10};
    tbl[2] = '{1'b1, 8'h22, 1'b0, 8'hDD, 1'b0, 2'b10, 2'b10};
    tbl[3] = '{1'b1, 8'h33, 1'b1, 8'hCC, 1'b0, 2'b10, 2'b10};
    tbl[4] = '{1'b0, 8'h0F, 1'b0, 8'hF0, 1'b1, 2'b01, 2'b01};
    tbl[5] = '{1'b0, 8'hF0, 1'b1, 8'h0F, 1'b0, 2'b01, 2'b01};
    tbl[6] = '{1'b1, 8'h5A, 1'b1, 8'h81, 1'b1, 2'b10, 2'b10};

    tx_valid = 2'b00;
    tx_data  = 16'h0000;
    tx_last  = 2'b00;
    eng_resp = 8'h00;
    do_reset();
    #1;
    check("rst_cs_n",     cs_n_o,      1);
    check("rst_grant",    grant_o,     0);
    check("rst_rx_valid", rx_valid_o,  0);
    check("rst_rx_data",  rx_data_o,   0);
    check("rst_timeout",  timeout_o,   0);
    check("rst_tx_ready", tx_ready_o,  0);
    check("rst_start",    eng_start_o, 0);
    check("rst_eng_data", eng_data_o,  0);

    // Table: single and multi-byte bursts, one requester at a time
    for (int i = 0; i < NV; i++) begin
      v = tbl[i];
      tx_data  = v.r ? {v.data, 8'h00} : {8'h00, v.data};
      tx_last  = v.r ? {v.last, 1'b0} : {1'b0, v.last};
      tx_valid = v.r ? 2'b10 : 2'b01;
      eng_resp = v.resp;
      c_cs = -1;
      ok   = 1'b0;
      for (int n = 0; n < 64; n++) begin
        #1;
        if (!cs_n_o && c_cs < 0) c_cs = cyc;
        if (eng_start_o) begin
          ok = 1'b1;
          break;
        end
        @(negedge clk);
      end
      check("start_seen", ok, 1);
      c_st = cyc;
      if (v.first) check("cs_to_start", c_st - c_cs, CS_SETUP);
      check("eng_data", eng_data_o, v.data);
      check("grant",    grant_o,    v.exp_grant);
      check("tx_ready", tx_ready_o, v.exp_grant);
      check("cs_low",   cs_n_o,     0);
      @(posedge clk);
      #1;
      tx_valid = 2'b00;
      ok = 1'b0;
      for (int n = 0; n < 64; n++) begin
        @(negedge clk);
        #1;
        if (rx_valid_o != 2'b00) begin
          ok = 1'b1;
          break;
        end
        check("cs_hold", cs_n_o, 0);
      end
      check("rx_seen",  ok,         1);
      check("rx_valid", rx_valid_o, v.exp_rxv);
      check("rx_data",  rx_data_o,  v.resp);
      if (v.last) begin
        check("rel_cs_n",  cs_n_o,  1);
        check("rel_grant", grant_o, 0);
        @(negedge clk);
        #1;
        check("gap_cs_n",  cs_n_o,     1);
        check("gap_grant", grant_o,    0);
        check("gap_rxv",   rx_valid_o, 0);
      end else begin
        check("mid_cs_n",  cs_n_o,  0);
        check("mid_grant", grant_o, v.exp_grant);
      end
    end

    // Round-robin: both requesters valid from reset, 1-byte bursts
    tx_valid = 2'b11;
    tx_last  = 2'b11;
    tx_data  = 16'h2010;
    eng_resp = 8'h55;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      wait_start(ok);
      check("rr_start",    ok,         1);
      check("rr_grant",    grant_o,    (i % 2 == 0) ? 2'b01 : 2'b10);
      check("rr_tx_ready", tx_ready_o, (i % 2 == 0) ? 2'b01 : 2'b10);
      check("rr_eng_data", eng_data_o, (i % 2 == 0) ? 8'h10 : 8'h20);
      @(posedge clk);
      #1;
      if (i == 3) tx_valid = 2'b00;
      @(negedge clk);
    end
    repeat (20) @(negedge clk);

    // Timeout: req0 leaves a burst open, req1 waits its turn
    tx_valid = 2'b00;
    do_reset();
    tx_data  = 16'h4401;
    tx_last  = 2'b10;
    tx_valid = 2'b01;
    eng_resp = 8'hC3;
    wait_start(ok);
    check("to_start", ok,      1);
    check("to_grant", grant_o, 2'b01);
    @(posedge clk);
    #1;
    tx_valid = 2'b10;
    wait_rx(ok);
    c_rx = cyc;
    check("to_rx",          rx_valid_o, 2'b01);
    check("to_nongrant_rd", tx_ready_o, 0);
    ok = 1'b0;
    for (int n = 0; n < 20; n++) begin
      if (timeout_o) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
      #1;
    end
    check("to_seen",  ok,         1);
    check("to_delay", cyc - c_rx, TMO);
    check("to_cs_n",  cs_n_o,     1);
    check("to_grant0", grant_o,   0);
    @(negedge clk);
    #1;
    check("to_pulse", timeout_o, 0);
    eng_resp = 8'h99;
    wait_start(ok);
    check("to_next_start", ok,         1);
    check("to_next_grant", grant_o,    2'b10);
    check("to_next_data",  eng_data_o, 8'h44);
    @(posedge clk);
    #1;
    tx_valid = 2'b00;
    wait_rx(ok);
    check("to_next_rxv",  rx_valid_o, 2'b10);
    check("to_next_rxd",  rx_data_o,  8'h99);
    check("to_next_cs_n", cs_n_o,     1);

    // Reset asserted during WAIT of a 2-byte burst
    @(negedge clk);
    tx_data  = 16'h0077;
    tx_last  = 2'b00;
    tx_valid = 2'b01;
    wait_start(ok);
    check("mr_start", ok, 1);
    @(posedge clk);
    #1;
    tx_valid = 2'b00;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    check("mr_cs_n",     cs_n_o,      1);
    check("mr_grant",    grant_o,     0);
    check("mr_rx_valid", rx_valid_o,  0);
    check("mr_timeout",  timeout_o,   0);
    check("mr_tx_ready", tx_ready_o,  0);
    check("mr_start0",   eng_start_o, 0);
    tx_valid = 2'b11;
    tx_last  = 2'b11;
    tx_data  = 16'hBBAA;
    rst_n    = 1'b1;
    wait_start(ok);
    check("mr_post_start", ok,         1);
    check("mr_post_grant", grant_o,    2'b01);
    check("mr_post_data",  eng_data_o, 8'hAA);
    @(posedge clk);
    #1;
    tx_valid = 2'b00;
    wait_rx(ok);
    check("mr_post_rxv", rx_valid_o, 2'b01);

    repeat (4) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
